// File: rtl/uart_pkg.sv
// Types and constants shared between the UART receiver and transmitter.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RST_VAL so the output never shows a spurious edge out of reset.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with CLKS_PER_BIT oversampling and a
// one-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int                HALF     = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

   logic                 w_rx_s;
   logic                 r_rx_prev;

   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [2:0]           r_idx;
   logic [2:0]           w_idx_nxt;
   logic [DATA_BITS-1:0] r_sr;
   logic [DATA_BITS-1:0] w_sr_nxt;
   logic                 w_byte_good;
   logic                 w_byte_bad;

   logic [DATA_BITS-1:0] r_out_data;
   logic                 r_out_valid;
   logic                 r_frame_err;
   logic                 r_overrun;

   sync2 #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rx),
      .o_q   (w_rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_prev <= 1'b1;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_sr      <= '0;
      end else begin
         r_rx_prev <= w_rx_s;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_sr      <= w_sr_nxt;
      end
   end

   // Only a high-to-low transition arms the receiver, so a held-low break
   // line cannot retrigger; STOP returns to IDLE at mid-stop-bit so a start
   // edge on the next nominal bit boundary is still caught.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_sr_nxt    = r_sr;
      w_byte_good = 1'b0;
      w_byte_bad  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_rx_prev && !w_rx_s) begin
               w_state_nxt = START;
               w_cnt_nxt   = '0;
            end
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
                  w_idx_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               w_sr_nxt  = {w_rx_s, r_sr[DATA_BITS-1:1]};
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               w_byte_good = w_rx_s;
               w_byte_bad  = !w_rx_s;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // A new byte may replace the buffered one only if that one leaves in the
   // same cycle; otherwise the new byte is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_byte_bad;
         r_overrun   <= 1'b0;
         if (w_byte_good) begin
            if (!r_out_valid || out_ready) begin
               r_out_data  <= r_sr;
               r_out_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences and random
// frames checked against a queue-based model of delivered bytes and flags.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int vld_cycles = 0;
   int first_vld = -1;

   always @(negedge clk) begin
      if (out_valid) begin
         vld_cycles++;
         if (first_vld < 0) first_vld = cyc;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      ferr_cnt   = 0;
      ovr_cnt    = 0;
      vld_cycles = 0;
      first_vld  = -1;
   endtask

   task automatic bit_time(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      bit_time(stop);
   endtask

   vec_t       vecs[7];
   logic [7:0] exp_q[$];
   int         exp_ferr;
   int         lat;

   initial begin
      vecs[0] = '{8'h48, 1'b1, 1, 8'h48, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[3] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1};
      vecs[5] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
      vecs[6] = '{8'h81, 1'b1, 1, 8'h81, 0};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cyc(2 * CPB);

      // single frame latency, pin fall to out_valid
      clear_mon();
      lat = cyc;
      send_frame(8'h48, 1'b1);
      idle_cyc(2 * CPB);
      lat = (first_vld < 0) ? -1 : first_vld - lat;
      check("lat_0x48", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
      check("lat_vld_cycles", vld_cycles, 1);
      check("lat_n", got_q.size(), 1);
      if (got_q.size() > 0) check("lat_data", got_q[0], 8'h48);

      // vector table
      for (int v = 0; v < 7; v++) begin
         clear_mon();
         send_frame(vecs[v].data, vecs[v].stop);
         idle_cyc(2 * CPB);
         check($sformatf("vec%0d_n", v), got_q.size(), vecs[v].exp_n);
         if (vecs[v].exp_n > 0 && got_q.size() > 0)
            check($sformatf("vec%0d_data", v), got_q[0], vecs[v].exp_data);
         check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
         check($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
      end

      // back to back, zero idle gap
      clear_mon();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'hA5, 1'b1);
      idle_cyc(2 * CPB);
      check("b2b_n", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("b2b_0", got_q[0], 8'h00);
         check("b2b_1", got_q[1], 8'hFF);
         check("b2b_2", got_q[2], 8'hA5);
      end
      check("b2b_ferr", ferr_cnt, 0);
      check("b2b_ovr", ovr_cnt, 0);

      // 3-cycle glitch alone
      clear_mon();
      rx = 1'b0;
      repeat (3) @(posedge clk); #1;
      idle_cyc(4 * CPB);
      check("glitch_n", got_q.size(), 0);
      check("glitch_ferr", ferr_cnt, 0);

      // glitch followed by a start edge that needs IDLE back by E0+9
      clear_mon();
      rx = 1'b0;
      repeat (3) @(posedge clk); #1;
      idle_cyc(6);
      send_frame(8'h5A, 1'b1);
      idle_cyc(2 * CPB);
      check("glitch_rearm_n", got_q.size(), 1);
      if (got_q.size() > 0) check("glitch_rearm_data", got_q[0], 8'h5A);
      check("glitch_rearm_ferr", ferr_cnt, 0);

      // framing error then a held-low break line
      clear_mon();
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      repeat (40 * CPB) @(posedge clk); #1;
      check("break_ferr", ferr_cnt, 1);
      check("break_n", got_q.size(), 0);
      check("break_vld", vld_cycles, 0);
      idle_cyc(2 * CPB);
      send_frame(8'h96, 1'b1);
      idle_cyc(2 * CPB);
      check("break_after_n", got_q.size(), 1);
      if (got_q.size() > 0) check("break_after_data", got_q[0], 8'h96);
      check("break_after_ferr", ferr_cnt, 1);

      // overrun with consumer stalled
      clear_mon();
      out_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      idle_cyc(2 * CPB);
      send_frame(8'h22, 1'b1);
      idle_cyc(2 * CPB);
      check("ovr_valid", out_valid, 1);
      check("ovr_data", out_data, 8'h11);
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_ferr", ferr_cnt, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ovr_drain_n", got_q.size(), 1);
      check("ovr_drain_valid", out_valid, 0);

      // consumer accepts on the very cycle the next byte is written
      clear_mon();
      send_frame(8'h11, 1'b1);
      idle_cyc(2 * CPB);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
         end
      join
      idle_cyc(CPB);
      check("same_cyc_ovr", ovr_cnt, 0);
      check("same_cyc_valid", out_valid, 1);
      check("same_cyc_data", out_data, 8'h22);
      check("same_cyc_n", got_q.size(), 1);
      if (got_q.size() > 0) check("same_cyc_first", got_q[0], 8'h11);
      out_ready = 1'b1;
      @(posedge clk); #1;

      // reset in the middle of a frame with a byte still buffered
      clear_mon();
      out_ready = 1'b0;
      send_frame(8'h99, 1'b1);
      idle_cyc(2 * CPB);
      check("pre_rst_valid", out_valid, 1);
      bit_time(1'b0);
      bit_time(1'b0);
      bit_time(1'b0);
      rx = 1'b1;
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_ferr", frame_err, 0);
      check("mid_rst_ovr", overrun, 0);
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle_cyc(2 * CPB);
      clear_mon();
      send_frame(8'hC3, 1'b1);
      idle_cyc(2 * CPB);
      check("post_rst_n", got_q.size(), 1);
      if (got_q.size() > 0) check("post_rst_data", got_q[0], 8'hC3);
      check("post_rst_ferr", ferr_cnt, 0);
      check("post_rst_ovr", ovr_cnt, 0);

      // random frames against the reference model
      clear_mon();
      exp_q.delete();
      exp_ferr = 0;
      for (int f = 0; f < 30; f++) begin
         logic [7:0] d;
         logic       stop;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop);
         if (stop) begin
            exp_q.push_back(d);
            idle_cyc($urandom_range(0, 2 * CPB));
         end else begin
            exp_ferr++;
            idle_cyc($urandom_range(CPB, 2 * CPB));
         end
      end
      idle_cyc(2 * CPB);
      check("rand_n", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
      check("rand_ferr", ferr_cnt, exp_ferr);
      check("rand_ovr", ovr_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
